// File: rtl/console_ctrl.sv
// Text-console sequencer: writes glyphs at the cursor into char_buf, handles
// control characters, line wrap, and hardware scroll that blanks the new row.
module console_ctrl #(
  parameter int          COLS  = 70,
  parameter int          ROWS  = 30,
  parameter int          PROWS = 32,
  parameter logic [31:0] BLANK = 32'hFFF00020
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  output logic        buf_we,
  output logic [11:0] buf_addr,
  output logic [31:0] buf_data,
  output logic [6:0]  h_cur,
  output logic [4:0]  v_cur,
  output logic [4:0]  line_offset,
  output logic        busy
);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [6:0] H_LAST = 7'(COLS - 1);
  localparam logic [4:0] V_LAST = 5'(ROWS - 1);
  localparam logic [4:0] R_LAST = 5'(PROWS - 1);

  typedef enum logic [2:0] {IDLE, EXEC, BS_WR, CLR_LINE, CLR_ALL, DONE} state_t;

  state_t      state_q, state_d;
  logic [6:0]  h_q, h_d, cnt_h_q, cnt_h_d;
  logic [4:0]  v_q, v_d, off_q, off_d, cnt_r_q, cnt_r_d;
  logic [31:0] cmd_q, cmd_d, data_q, data_d;
  logic [11:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic        nl;
  logic [4:0]  prow;
  logic [7:0]  ch;

  assign prow = v_q + off_q;
  assign ch   = cmd_q[7:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= CLR_ALL;
      h_q     <= '0;
      v_q     <= '0;
      off_q   <= '0;
      cnt_h_q <= '0;
      cnt_r_q <= '0;
      cmd_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      off_q   <= off_d;
      cnt_h_q <= cnt_h_d;
      cnt_r_q <= cnt_r_d;
      cmd_q   <= cmd_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    off_d   = off_q;
    cnt_h_d = cnt_h_q;
    cnt_r_d = cnt_r_q;
    cmd_d   = cmd_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    nl      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d   = cmd_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = IDLE;
        if (ch >= 8'h20 && ch <= 8'h7E) begin
          we_d    = 1'b1;
          addr_d  = {h_q, prow};
          data_d  = cmd_q;
          state_d = DONE;
          if (h_q == H_LAST) begin
            h_d = '0;
            nl  = 1'b1;
          end else begin
            h_d = h_q + 7'd1;
          end
        end else begin
          case (ch)
            CH_LF: begin
              h_d = '0;
              nl  = 1'b1;
            end
            CH_CR: h_d = '0;
            CH_BS: begin
              if (h_q != 7'd0) begin
                h_d     = h_q - 7'd1;
                state_d = BS_WR;
              end else if (v_q != 5'd0) begin
                h_d     = H_LAST;
                v_d     = v_q - 5'd1;
                state_d = BS_WR;
              end
            end
            CH_FF: begin
              h_d     = '0;
              v_d     = '0;
              off_d   = '0;
              cnt_h_d = '0;
              cnt_r_d = '0;
              state_d = CLR_ALL;
            end
            default: ;
          endcase
        end
        // Bottom-row newline: blank the row about to scroll in before advancing.
        if (nl) begin
          if (v_q < V_LAST) begin
            v_d = v_q + 5'd1;
          end else begin
            cnt_h_d = '0;
            cnt_r_d = 5'(ROWS) + off_q;
            state_d = CLR_LINE;
          end
        end
      end
      BS_WR: begin
        we_d    = 1'b1;
        addr_d  = {h_q, prow};
        data_d  = BLANK;
        state_d = DONE;
      end
      CLR_LINE: begin
        we_d   = 1'b1;
        addr_d = {cnt_h_q, cnt_r_q};
        data_d = BLANK;
        if (cnt_h_q == H_LAST) begin
          cnt_h_d = '0;
          off_d   = off_q + 5'd1;
          state_d = DONE;
        end else begin
          cnt_h_d = cnt_h_q + 7'd1;
        end
      end
      CLR_ALL: begin
        we_d   = 1'b1;
        addr_d = {cnt_h_q, cnt_r_q};
        data_d = BLANK;
        if (cnt_h_q == H_LAST) begin
          cnt_h_d = '0;
          cnt_r_d = cnt_r_q + 5'd1;
          if (cnt_r_q == R_LAST) state_d = DONE;
        end else begin
          cnt_h_d = cnt_h_q + 7'd1;
        end
      end
      // The last registered write is on the bus this cycle.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = ~cmd_ready;
  assign buf_we      = we_q;
  assign buf_addr    = addr_q;
  assign buf_data    = data_q;
  assign h_cur       = h_q;
  assign v_cur       = v_q;
  assign line_offset = off_q;

endmodule

// File: tb/tb_console_ctrl.sv
// Scoreboard bench for console_ctrl: stimulus queues expected char_buf writes,
// a negedge monitor pops and compares every buf_we pulse.
module tb_console_ctrl;

  localparam logic [31:0] BLANK = 32'hFFF00020;

  logic        clock, reset, cmd_valid, cmd_ready, buf_we, busy;
  logic [31:0] cmd_data, buf_data;
  logic [11:0] buf_addr;
  logic [6:0]  h_cur;
  logic [4:0]  v_cur, line_offset;

  int n_run  = 0;
  int n_fail = 0;
  logic [43:0] exp_q[$];

  console_ctrl dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
    .h_cur(h_cur), .v_cur(v_cur), .line_offset(line_offset), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_w(input int h, input int r, input logic [31:0] d);
    logic [6:0] hh;
    logic [4:0] rr;
    hh = 7'(h);
    rr = 5'(r);
    exp_q.push_back({hh, rr, d});
  endtask

  task automatic push_row(input int r);
    for (int h = 0; h < 70; h++) push_w(h, r, BLANK);
  endtask

  task automatic push_all();
    for (int r = 0; r < 32; r++) push_row(r);
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1 && buf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h", buf_addr, buf_data);
      end else begin
        chk("write", 64'({buf_addr, buf_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic issue(input logic [31:0] d);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_data  = d;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  // Cycles from accept edge to cmd_ready; optionally require a write on the bus
  // in the cycle just before ready rises.
  task automatic wait_ready(input int exp_lat, input bit tail, input string nm);
    int   lat;
    logic pwe;
    lat = 0;
    pwe = buf_we;
    do begin
      pwe = buf_we;
      @(posedge clock);
      #1 lat++;
    end while (!cmd_ready && lat < 5000);
    if (!cmd_ready) begin
      n_run++;
      n_fail++;
      $display("FAIL %s_timeout: ready still %0b after %0d cycles", nm, cmd_ready, lat);
    end
    if (exp_lat >= 0) chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    if (tail) begin
      chk({nm, "_last_we"}, 64'(pwe), 64'd1);
      chk({nm, "_we_after"}, 64'(buf_we), 64'd0);
    end
  endtask

  task automatic send(input logic [31:0] d, input int exp_lat, input string nm);
    issue(d);
    wait_ready(exp_lat, exp_lat > 0 && exp_lat != 1, nm);
  endtask

  task automatic chk_cur(input string nm, input int h, input int v, input int off);
    chk({nm, "_h"}, 64'(h_cur), 64'(h));
    chk({nm, "_v"}, 64'(v_cur), 64'(v));
    chk({nm, "_off"}, 64'(line_offset), 64'(off));
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_we"}, 64'(buf_we), 64'd0);
    chk({nm, "_addr"}, 64'(buf_addr), 64'd0);
    chk({nm, "_data"}, 64'(buf_data), 64'd0);
    chk({nm, "_ready"}, 64'(cmd_ready), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    chk_cur(nm, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d run", n_run);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    #2 reset  = 1'b0;
    #1 chk_reset_outs("reset");

    // Reset release: full clear of all 32 physical rows.
    push_all();
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b1;
    wait_ready(-1, 1'b1, "init_clear");
    chk("init_clear_drained", 64'(exp_q.size()), 64'd0);
    chk_cur("init", 0, 0, 0);

    push_w(0, 0, 32'h0F000041);
    send(32'h0F000041, 2, "char_A");
    chk_cur("after_A", 1, 0, 0);

    send(32'h0000000D, -1, "cr");
    for (int i = 0; i < 5; i++) send(32'h0000000A, -1, "lf");
    chk_cur("at_0_5", 0, 5, 0);

    // A full line wraps to the next row without scrolling.
    for (int i = 0; i < 70; i++) begin
      d = {12'h0F0, 12'h00F, 8'(8'h41 + i % 26)};
      push_w(i, 5, d);
      send(d, 2, "line");
    end
    chk_cur("wrap", 0, 6, 0);

    for (int i = 0; i < 23; i++) send(32'h0000000A, -1, "lf");
    chk_cur("at_0_29", 0, 29, 0);

    // Scroll 31 times; each blanks row (30+off) mod 32 before advancing.
    for (int k = 0; k < 31; k++) begin
      push_row((30 + k) % 32);
      send(32'h0000000A, 72, "scroll");
    end
    chk_cur("off31", 0, 29, 31);
    for (int i = 0; i < 3; i++) begin
      d = {24'h123456, 8'(8'h78 + i)};
      push_w(i, 28, d);
      send(d, 2, "bottom_chars");
    end
    chk_cur("at_3_29", 3, 29, 31);
    push_row(29);
    send(32'h0000000A, 72, "scroll_wrap");
    chk_cur("offset_wrap", 0, 29, 0);

    push_all();
    send(32'h0000000C, 2242, "ff");
    chk_cur("after_ff", 0, 0, 0);

    for (int i = 0; i < 4; i++) send(32'h0000000A, -1, "lf");
    push_w(69, 3, BLANK);
    send(32'h00000008, 3, "bs_row_up");
    chk_cur("bs_row_up", 69, 3, 0);

    push_all();
    send(32'h0000000C, 2242, "ff2");
    push_w(0, 0, 32'hABCDEF42);
    send(32'hABCDEF42, 2, "char_B");
    push_w(0, 0, BLANK);
    send(32'h00000008, 3, "bs_left");
    chk_cur("bs_left", 0, 0, 0);
    send(32'h00000008, -1, "bs_origin");
    chk_cur("bs_origin", 0, 0, 0);
    send(32'h00000001, -1, "ctrl_other");
    chk_cur("ctrl_other", 0, 0, 0);

    // Reset in the middle of a scroll clear.
    for (int i = 0; i < 29; i++) send(32'h0000000A, -1, "lf");
    push_row(30);
    issue(32'h0000000A);
    repeat (20) @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    #1 chk_reset_outs("mid_reset");
    push_all();
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b1;
    wait_ready(-1, 1'b1, "reclear");
    chk("reclear_drained", 64'(exp_q.size()), 64'd0);
    chk_cur("after_reclear", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/console_ctrl.md
Name: console_ctrl

Overview:
- Text-console sequencer for the VGA character buffer (char_buf); sits between the CPU MMIO write path and the buffer write port.
- Accepts one character command at a time and writes the glyph with its colours at the cursor.
- Maintains cursor (h_cur/v_cur) and scroll offset (line_offset); handles control characters, line wrap and scroll.
- Scroll is hardware-driven: the new bottom row is blanked before the view is advanced.

Parameters:
COLS, 70, visible columns per row (cursor h range 0..COLS-1)
ROWS, 30, visible rows (cursor v range 0..ROWS-1)
PROWS, 32, physical rows in char_buf (2^5; row index wraps mod 32)
BLANK, 32'hFFF00020, fill word {fg 12'hFFF, bg 12'h000, char 8'h20}

Ports:
clock  in  1  system clock; all state on posedge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command this cycle
cmd_data  in  32  {fg[11:0], bg[11:0], char[7:0]}
buf_we  out  1  char_buf write enable (registered)
buf_addr  out  12  {h[6:0], physical_row[4:0]} (registered)
buf_data  out  32  word to write (registered)
h_cur  out  7  cursor column, screen-relative
v_cur  out  5  cursor row, screen-relative
line_offset  out  5  physical row shown on screen row 0
busy  out  1  equals ~cmd_ready

Behaviour:
- States:
  - IDLE: cmd_ready=1.
  - EXEC: 1 cycle.
  - CLR_LINE: COLS cycles.
  - CLR_ALL: COLS*PROWS = 2240 cycles.
- cmd_ready is high only in IDLE. A command is accepted on the edge where cmd_valid & cmd_ready; cmd_data is captured then. The next state is EXEC.
- Reset (reset=0, async):
  - h_cur=0, v_cur=0, line_offset=0, buf_we=0, buf_addr=0, buf_data=0.
  - State is CLR_ALL; cmd_ready=0 until the clear completes.
  - Reset asserted mid-operation aborts it immediately and restarts CLR_ALL after release.
- Physical row = (v + line_offset) mod 32, 5-bit wrap.
- EXEC, by char:
  - 0x20..0x7E:
    - buf_we=1, buf_addr={h_cur, prow(v_cur)}, buf_data=cmd_data.
    - Then h_cur+1. If h_cur was COLS-1: h_cur=0 and take the newline action.
  - 0x0A (LF): h_cur=0, newline action. No write.
  - 0x0D (CR): h_cur=0. No write.
  - 0x08 (BS):
    - If h_cur>0: h_cur-1.
    - Else if v_cur>0: h_cur=COLS-1, v_cur-1.
    - Else (0,0): no-op, no write.
    - When the cursor moves, write BLANK at the new cursor position during the next cycle (EXEC extends 1 cycle).
  - 0x0C (FF): h_cur=0, v_cur=0, line_offset=0, then CLR_ALL.
  - Any other char: consumed, no effect, back to IDLE.
- Newline action:
  - If v_cur<ROWS-1: v_cur+1, return to IDLE.
  - Else: v_cur stays ROWS-1; go to CLR_LINE targeting physical row (ROWS + line_offset) mod 32, i.e. the row that becomes visible.
- CLR_LINE:
  - Writes BLANK at h=0..COLS-1, one per cycle, buf_we=1 each cycle.
  - On the edge leaving the last write, line_offset increments mod 32; then IDLE.
  - Rows never scroll into view un-cleared.
- CLR_ALL:
  - Writes BLANK at every (h, prow) with h 0..COLS-1 and prow 0..31.
  - h is the inner loop, prow the outer loop.
  - Then IDLE.
- Latencies, accept edge to cmd_ready high again:
  - Printable without scroll: 2 cycles.
  - BS with write: 3 cycles.
  - Scroll: 2+COLS cycles.
  - FF: 2+2240 cycles.
- buf_we is 0 in every cycle not listed above. buf_addr and buf_data hold their last values when buf_we=0.
- Column counter never exceeds COLS-1. Addresses h>=COLS are never written.
- line_offset wraps 31->0 with no special case.

Test Plan:
- Reset release -> 2240 consecutive buf_we pulses, all with data 32'hFFF00020; cursor (0,0); cmd_ready rises on the following cycle.
- Send 'A' with cmd_data=32'h0F000041 at cursor (0,0), offset 0 -> one write, addr {7'd0,5'd0}, data 32'h0F000041; h_cur=1; ready again 2 cycles after accept.
- Send 70 printable chars from (0,5) -> last write at h=69 row 5; cursor (0,6); no CLR_LINE.
- Cursor (3,29), line_offset=31, send LF -> 70 blank writes to prow (30+31)%32=29, h 0..69; line_offset becomes 0; cursor (0,29).
- BS at (0,4) -> cursor (69,3), BLANK written at {69, prow(3)}. BS at (0,0) -> no write, cursor unchanged.
- Assert reset mid-CLR_LINE, then release -> all outputs zero during reset; CLR_ALL runs fully; line_offset=0.
